seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Drives the digit-select code `en[1:0]` and digit code `bcd[3:0]` consumed by the 7447-style segment/anode decoder.
- Accepts a 4-digit BCD word through a load strobe and commits it only at frame boundaries, so no displayed frame mixes old and new digits.
- Cycles `en` 0→1→2→3 at a programmable refresh rate and provides leading-zero blanking and invalid-digit flagging.

Parameters:
- DIV, 100000: clk cycles each digit stays selected (≥2).
- BLANK_CODE, 4'd10: code driven on `bcd` for a blanked or invalid digit (10 renders a dash on the decoder).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- value  input  16  four BCD digits; [15:12] leftmost (en=0), [3:0] rightmost (en=3).
- load  input  1  single-cycle strobe; capture `value` into the shadow register.
- blank_lz  input  1  1 = replace leading zero digits with BLANK_CODE.
- en  output  2  digit select to the decoder; 0 = leftmost anode.
- bcd  output  4  digit code for the currently selected digit.
- frame_tick  output  1  one-cycle pulse marking the first cycle of each new frame.
- pending  output  1  shadow holds a loaded word not yet committed.
- err  output  1  the committed word contains a digit >9.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - prescaler cnt=0, en=0.
  - disp (committed) = shadow = 16'hAAAA.
  - pending=0, frame_tick=0, err=0.
  - bcd=BLANK_CODE (dashes displayed).
- Reset mid-operation: any assertion immediately forces all registers to their reset values, including a pending load, which is discarded.
- Prescaler:
  - cnt counts 0..DIV-1. At cnt==DIV-1, cnt→0 and en increments modulo 4 (3 wraps to 0).
  - Each digit is therefore held for exactly DIV cycles; a frame is 4*DIV cycles.
- Wrap edge: the edge where en goes 3→0.
  - frame_tick is registered and is 1 only in the cycle immediately after the wrap edge.
  - If pending=1 at the wrap edge: disp←shadow, pending←0.
- Load:
  - On an edge with load=1: shadow←value, pending←1.
  - Load on the wrap edge: value is committed directly to disp, shadow←value, pending ends 0.
  - Repeated loads before a commit: last one wins, earlier ones are discarded.
  - load is ignored only during reset.
- Commit latency: a word loaded while en≠3 or cnt≠DIV-1 appears at the start of the next frame. Worst case is 4*DIV cycles.
- bcd:
  - Combinational from registered en and disp; it changes in the same cycle as en.
  - Digit d = disp nibble selected by en.
  - Digit d>9 → bcd=BLANK_CODE.
  - Leading-zero blanking (blank_lz=1): digit d is blanked (bcd=BLANK_CODE) if it and every digit to its left are 0. The rightmost digit is never blanked, so 0000 shows as blank, blank, blank, 0.
  - blank_lz=0 → zeros are displayed.
  - blank_lz is sampled combinationally, not frame-aligned.
- err: combinational OR of (nibble>9) across the four nibbles of disp. It is 1 after reset because 16'hAAAA holds invalid digits, and stays 1 until a valid word is committed.
- No other state; en never skips or repeats a value except when reset.

Test Plan:
- Reset, DIV=4: release rst_n → en sequence 0,0,0,0,1,1,1,1,2…; bcd=10 throughout; err=1; frame_tick first high 16 cycles after release.
- load value=16'h1234 at cnt=1, en=1 → pending=1; disp unchanged until the wrap edge; then bcd sequence 1,2,3,4 for en 0..3, pending=0, err=0.
- load 16'h0007 with blank_lz=1 → bcd 10,10,10,7. Then blank_lz=0 → bcd 0,0,0,7. Then load 16'h0000 with blank_lz=1 → bcd 10,10,10,0.
- load 16'h1111, then 16'h2222 three cycles later in the same frame → next frame shows 2,2,2,2; 1111 is never displayed.
- load 16'h5678 exactly on the wrap edge → bcd=5 in the first cycle of frame (frame_tick=1); pending=0 in that cycle.
- load 16'h9A00 committed → err=1; en=1 shows bcd=10, en=0 shows 9. Assert rst_n=0 mid-digit with a load pending → en=0, pending=0, bcd=10 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: frame-aligned commit of a shadowed BCD word,
// leading-zero blanking and invalid-digit flagging.
module seg_scan_digit #(
  parameter logic [3:0] BLANK_CODE = 4'd10,
  parameter bit         LAST       = 1'b0
) (
  input  logic [3:0] nib_i,
  input  logic       lz_i,
  input  logic       blank_lz_i,
  output logic [3:0] code_o,
  output logic       lz_o,
  output logic       inv_o
);
  assign inv_o  = (nib_i > 4'd9);
  // lz_o: this digit and everything left of it is zero.
  assign lz_o   = lz_i & (nib_i == 4'd0);
  assign code_o = (inv_o || (blank_lz_i && lz_o && !LAST)) ? BLANK_CODE : nib_i;
endmodule

module seg_scan_ctrl #(
  parameter int         DIV        = 100000,
  parameter logic [3:0] BLANK_CODE = 4'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [1:0]  en,
  output logic [3:0]  bcd,
  output logic        frame_tick,
  output logic        pending,
  output logic        err
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    en_q, en_d;
  logic [15:0]   disp_q, disp_d, shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          tick_q;
  logic          digit_end, wrap;

  assign digit_end = (cnt_q == CNT_MAX);
  assign wrap      = digit_end && (en_q == 2'd3);

  always_comb begin
    cnt_d     = digit_end ? '0 : cnt_q + 1'b1;
    en_d      = digit_end ? en_q + 2'd1 : en_q;
    shadow_d  = load ? value : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (load) pending_d = 1'b1;
    // A load on the wrap edge bypasses the shadow and lands in this frame.
    if (wrap) begin
      pending_d = 1'b0;
      if (load)           disp_d = value;
      else if (pending_q) disp_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      en_q      <= 2'd0;
      disp_q    <= 16'hAAAA;
      shadow_q  <= 16'hAAAA;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= wrap;
    end
  end

  logic [3:0][3:0] code;
  logic [4:0]      lz_chain;
  logic [3:0]      inv;

  assign lz_chain[0] = 1'b1;

  // Digit i is display position i (0 = leftmost = value[15:12]).
  for (genvar i = 0; i < 4; i++) begin : g_dig
    seg_scan_digit #(
      .BLANK_CODE (BLANK_CODE),
      .LAST       (i == 3)
    ) u_dig (
      .nib_i      (disp_q[15-4*i -: 4]),
      .lz_i       (lz_chain[i]),
      .blank_lz_i (blank_lz),
      .code_o     (code[i]),
      .lz_o       (lz_chain[i+1]),
      .inv_o      (inv[i])
    );
  end

  assign en         = en_q;
  assign bcd        = code[en_q];
  assign frame_tick = tick_q;
  assign pending    = pending_q;
  assign err        = |inv;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIV=4): expected digit codes are queued when a
// word is loaded and popped as each digit of the following frame is displayed.
module tb_seg_scan_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [1:0]  en;
  logic [3:0]  bcd;
  logic        frame_tick;
  logic        pending;
  logic        err;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  seg_scan_ctrl #(.DIV(DIV), .BLANK_CODE(4'd10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .en         (en),
    .bcd        (bcd),
    .frame_tick (frame_tick),
    .pending    (pending),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 4*DIV + 2) begin
      step(1);
      k++;
    end
    chk("tick_wait", {31'd0, frame_tick}, 32'd1);
  endtask

  // Checks one frame against the next four queued codes; ends at en=3, cnt=0.
  task automatic show_frame(input string tag);
    logic [3:0] e;
    wait_tick();
    for (int d = 0; d < 4; d++) begin
      chk({tag, "_en"}, {30'd0, en}, d);
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_bcd"}, {28'd0, bcd}, {28'd0, e});
      end
      if (d < 3) step(DIV);
    end
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; value = 16'h0; load = 1'b0; blank_lz = 1'b0;
    step(3);
    chk("rst_en",      {30'd0, en},         0);
    chk("rst_bcd",     {28'd0, bcd},        10);
    chk("rst_pending", {31'd0, pending},    0);
    chk("rst_tick",    {31'd0, frame_tick}, 0);
    chk("rst_err",     {31'd0, err},        1);

    // Release between edges; tick must first appear after the 16th edge.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("scan_en",   {30'd0, en},         ((i + 1) / DIV) % 4);
      chk("scan_bcd",  {28'd0, bcd},        10);
      chk("scan_tick", {31'd0, frame_tick}, (i == 15) ? 1 : 0);
    end

    // Load mid-frame at en=1, cnt=1: held in shadow until the wrap.
    step(DIV + 1);
    chk("pre_en", {30'd0, en}, 1);
    do_load(16'h1234);
    chk("pend_set",  {31'd0, pending}, 1);
    chk("disp_hold", {28'd0, bcd},     10);
    chk("err_hold",  {31'd0, err},     1);
    push4(4'd1, 4'd2, 4'd3, 4'd4);
    show_frame("f1234");
    chk("pend_clr", {31'd0, pending}, 0);
    chk("err_clr",  {31'd0, err},     0);

    blank_lz = 1'b1;
    do_load(16'h0007);
    push4(4'd10, 4'd10, 4'd10, 4'd7);
    show_frame("lz0007");
    blank_lz = 1'b0;
    push4(4'd0, 4'd0, 4'd0, 4'd7);
    show_frame("nolz0007");
    blank_lz = 1'b1;
    do_load(16'h0000);
    push4(4'd10, 4'd10, 4'd10, 4'd0);
    show_frame("lz0000");

    // Two loads in one frame: only the later word is ever shown.
    blank_lz = 1'b0;
    step(DIV);
    chk("f2_start", {31'd0, frame_tick}, 1);
    do_load(16'h1111);
    step(2);
    do_load(16'h2222);
    chk("pend_2222", {31'd0, pending}, 1);
    push4(4'd2, 4'd2, 4'd2, 4'd2);
    show_frame("last_wins");

    // Load exactly on the wrap edge commits immediately.
    step(DIV - 1);
    do_load(16'h5678);
    chk("wrap_tick", {31'd0, frame_tick}, 1);
    chk("wrap_en",   {30'd0, en},         0);
    chk("wrap_bcd",  {28'd0, bcd},        5);
    chk("wrap_pend", {31'd0, pending},    0);
    push4(4'd5, 4'd6, 4'd7, 4'd8);
    show_frame("wrap5678");

    do_load(16'h9A00);
    push4(4'd9, 4'd10, 4'd0, 4'd0);
    show_frame("inv9A00");
    chk("err_9A00", {31'd0, err}, 1);

    // Asynchronous reset with a load pending discards it.
    step(DIV + 1);
    do_load(16'h1234);
    step(DIV);
    chk("pre_rst_en",   {30'd0, en},      1);
    chk("pre_rst_pend", {31'd0, pending}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en",   {30'd0, en},      0);
    chk("arst_pend", {31'd0, pending}, 0);
    chk("arst_bcd",  {28'd0, bcd},     10);
    chk("arst_err",  {31'd0, err},     1);
    step(2);
    rst_n = 1'b1;
    push4(4'd10, 4'd10, 4'd10, 4'd10);
    show_frame("post_rst");
    chk("post_rst_pend", {31'd0, pending}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
